// File: rtl/pid_pressure_controller.sv
// pid_pressure_controller: shared-multiplier PID stage producing a saturated pump actuation word
module pid_pressure_controller #(
  parameter int                 GAIN_FRAC = 8,
  parameter logic signed [31:0] INT_LIMIT = 32'sd100000,
  parameter logic signed [15:0] OUT_MAX   = 16'sd1000,
  parameter logic signed [15:0] OUT_MIN   = -16'sd1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic [15:0] setpoint,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] kp,
  input  logic [15:0] ki,
  input  logic [15:0] kd,
  output logic [15:0] pid_out,
  output logic        pid_valid,
  output logic        saturated
);
  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, SUM, SAT} state_t;
  localparam logic signed [32:0] LIM_W = 33'(INT_LIMIT);
  localparam logic signed [49:0] MAX_W = 50'(OUT_MAX);
  localparam logic signed [49:0] MIN_W = 50'(OUT_MIN);
  state_t state, state_n;
  logic ready_q, accept, first;
  logic signed [16:0] err, err_n, prev_err;
  logic signed [17:0] deriv, deriv_n;
  logic signed [31:0] integ, integ_n;
  logic signed [32:0] integ_sum;
  logic [15:0] kp_q, ki_q, kd_q;
  logic signed [31:0] op_a;
  logic signed [16:0] op_b;
  logic signed [48:0] prod;
  logic signed [49:0] prod_w, acc, sh;
  assign sample_ready = ready_q & Start;
  assign accept = sample_valid & sample_ready;
  // next state: any Start drop abandons the computation in flight
  always_comb begin
    state_n = !Start ? IDLE :
              state == IDLE ? (accept ? MUL_P : IDLE) :
              state == SAT ? IDLE : state_t'(state + 3'd1);
  end
  // error terms for the incoming sample and the single shared multiplier
  always_comb begin
    err_n = $signed({setpoint[15], setpoint}) - $signed({sample[15], sample});
    deriv_n = first ? 18'sd0 : $signed({err_n[16], err_n}) - $signed({prev_err[16], prev_err});
    integ_sum = $signed({integ[31], integ}) + $signed({{16{err_n[16]}}, err_n});
    integ_n = integ_sum > LIM_W ? INT_LIMIT : integ_sum < -LIM_W ? -INT_LIMIT : integ_sum[31:0];
    op_a = state == MUL_P ? {{15{err[16]}}, err} : state == MUL_I ? integ : {{14{deriv[17]}}, deriv};
    op_b = state == MUL_P ? {1'b0, kp_q} : state == MUL_I ? {1'b0, ki_q} : {1'b0, kd_q};
    prod = op_a * op_b;
    prod_w = {prod[48], prod};
  end
  // state register
  always_ff @(posedge CLK) state <= RESET ? IDLE : state_n;
  // loop memory and outputs, cleared whenever the loop is reset or disabled
  always_ff @(posedge CLK) begin
    if (RESET || !Start) begin
      ready_q <= 1'b0;
      pid_valid <= 1'b0;
      pid_out <= '0;
      saturated <= 1'b0;
      integ <= '0;
      prev_err <= '0;
      first <= 1'b1;
    end else begin
      ready_q <= state_n == IDLE;
      pid_valid <= state == SAT;
      if (accept) begin
        integ <= integ_n;
        prev_err <= err_n;
        first <= 1'b0;
      end
      if (state == SAT) begin
        pid_out <= sh > MAX_W ? OUT_MAX : sh < MIN_W ? OUT_MIN : sh[15:0];
        saturated <= sh > MAX_W || sh < MIN_W;
      end
    end
  end
  // operand capture and multiply-accumulate; always rewritten before being read
  always_ff @(posedge CLK) begin
    if (accept) begin
      err <= err_n;
      deriv <= deriv_n;
      kp_q <= kp;
      ki_q <= ki;
      kd_q <= kd;
    end
    acc <= state == MUL_P ? prod_w : (state == MUL_I || state == MUL_D) ? acc + prod_w : acc;
    if (state == SUM) sh <= acc >>> GAIN_FRAC;
  end
endmodule

// File: tb/tb_pid_pressure_controller.sv
// tb_pid_pressure_controller: directed and randomized checks against a plain-arithmetic PID model
module tb_pid_pressure_controller;
  logic CLK = 1'b0;
  logic RESET = 1'b1, Start = 1'b0, sample_valid = 1'b0;
  logic signed [15:0] setpoint = '0, sample = '0;
  logic [15:0] kp = '0, ki = '0, kd = '0;
  logic sample_ready, pid_valid, saturated, sample_ready2, pid_valid2, saturated2;
  logic signed [15:0] pid_out, pid_out2;
  int tests = 0, fails = 0, cyc = 0;
  bit accepted, got_valid, m_first = 1'b1;
  longint m_int0 = 0, m_int1 = 0, m_prev = 0;
  longint q_o0[$], q_o1[$], q_t[$];
  bit q_s0[$], q_s1[$];

  pid_pressure_controller dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .setpoint(setpoint), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .kp(kp), .ki(ki), .kd(kd),
    .pid_out(pid_out), .pid_valid(pid_valid), .saturated(saturated)
  );
  pid_pressure_controller #(.INT_LIMIT(32'sd25)) dut_lim (
    .CLK(CLK), .RESET(RESET), .Start(Start), .setpoint(setpoint), .sample(sample),
    .sample_valid(sample_valid), .sample_ready(sample_ready2), .kp(kp), .ki(ki), .kd(kd),
    .pid_out(pid_out2), .pid_valid(pid_valid2), .saturated(saturated2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampl(longint v, longint lim);
    return v > lim ? lim : v < -lim ? -lim : v;
  endfunction

  task automatic model_accept();
    longint e, d, gp, gi, gd, s0, s1;
    gp = kp; gi = ki; gd = kd;
    e = setpoint - sample;
    d = m_first ? 0 : e - m_prev;
    m_prev = e;
    m_first = 1'b0;
    m_int0 = clampl(m_int0 + e, 100000);
    m_int1 = clampl(m_int1 + e, 25);
    s0 = (gp * e + gi * m_int0 + gd * d) >>> 8;
    s1 = (gp * e + gi * m_int1 + gd * d) >>> 8;
    q_o0.push_back(clampl(s0, 1000));
    q_s0.push_back(clampl(s0, 1000) != s0);
    q_o1.push_back(clampl(s1, 1000));
    q_s1.push_back(clampl(s1, 1000) != s1);
    q_t.push_back(cyc);
  endtask

  task automatic step();
    logic acc_now, st_now, rs_now;
    bit exp_rdy;
    acc_now = sample_valid && sample_ready;
    st_now = Start;
    rs_now = RESET;
    @(posedge CLK);
    #1;
    cyc++;
    accepted = acc_now && st_now && !rs_now;
    got_valid = pid_valid;
    if (rs_now || !st_now) begin
      m_int0 = 0; m_int1 = 0; m_prev = 0; m_first = 1'b1;
      q_o0.delete(); q_o1.delete(); q_s0.delete(); q_s1.delete(); q_t.delete();
      chk("clr_out", pid_out, 0);
      chk("clr_sat", saturated, 0);
      chk("clr_valid", pid_valid, 0);
      chk("clr_out2", pid_out2, 0);
    end else begin
      if (accepted) model_accept();
      if (pid_valid) begin
        if (q_t.size() == 0) chk("spurious_valid", pid_valid, 0);
        else begin
          chk("latency", cyc - q_t.pop_front(), 5);
          chk("pid_out", pid_out, q_o0.pop_front());
          chk("saturated", saturated, q_s0.pop_front());
          chk("pid_valid2", pid_valid2, 1);
          chk("pid_out2", pid_out2, q_o1.pop_front());
          chk("saturated2", saturated2, q_s1.pop_front());
        end
      end
    end
    exp_rdy = q_t.size() == 0 && st_now && !rs_now;
    chk("ready", sample_ready, exp_rdy);
    chk("ready2", sample_ready2, exp_rdy);
  endtask

  task automatic accept_only(input logic signed [15:0] sp, input logic signed [15:0] s);
    setpoint = sp;
    sample = s;
    sample_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (accepted) break;
    end
    sample_valid = 1'b0;
    chk("accept_seen", accepted, 1);
  endtask

  task automatic send(input logic signed [15:0] sp, input logic signed [15:0] s);
    accept_only(sp, s);
    for (int n = 0; n < 10; n++) begin
      step();
      if (got_valid) break;
    end
    chk("result_seen", got_valid, 1);
  endtask

  task automatic restart();
    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
  endtask

  initial begin
    longint vals[2];
    int vn, n, last;
    bit pend;
    repeat (3) step();
    chk("rst_ready", sample_ready, 0);
    RESET = 1'b0;
    Start = 1'b1;
    step();
    // T1: proportional only
    kp = 16'd256;
    send(16'sd500, 16'sd100);
    chk("t1_out", pid_out, 400);
    chk("t1_sat", saturated, 0);
    step();
    chk("t1_pulse", pid_valid, 0);
    step();
    chk("t1_hold", pid_out, 400);
    // T2: saturation both ways
    send(16'sd3000, 16'sd0);
    chk("t2_hi", pid_out, 1000);
    chk("t2_hi_sat", saturated, 1);
    send(16'sd0, 16'sd2000);
    chk("t2_lo", pid_out, -1000);
    chk("t2_lo_sat", saturated, 1);
    // T3: integral, default and tight clamp
    restart();
    kp = 0; ki = 16'd256; kd = 0;
    send(16'sd10, 16'sd0);
    chk("t3_a", pid_out, 10);
    chk("t3_a2", pid_out2, 10);
    send(16'sd10, 16'sd0);
    chk("t3_b", pid_out, 20);
    chk("t3_b2", pid_out2, 20);
    send(16'sd10, 16'sd0);
    chk("t3_c", pid_out, 30);
    chk("t3_c2", pid_out2, 25);
    // T4: derivative with valid held through busy cycles
    restart();
    ki = 0; kd = 16'd256;
    setpoint = 16'sd100; sample = 16'sd0; sample_valid = 1'b1;
    n = 0; vn = 0; vals = '{-1, -1};
    for (int i = 0; i < 12; i++) begin
      step();
      if (accepted) begin n++; setpoint = 16'sd150; end
      if (got_valid && vn < 2) begin vals[vn] = pid_out; vn++; end
    end
    sample_valid = 1'b0;
    chk("t4_accepts", n, 2);
    chk("t4_first", vals[0], 0);
    chk("t4_second", vals[1], 50);
    // T5: Start dropped mid-computation
    kp = 16'd256; ki = 16'd256; kd = 16'd256;
    accept_only(16'sd510, 16'sd500);
    step();
    Start = 1'b0;
    step();
    chk("t5_out", pid_out, 0);
    repeat (3) step();
    Start = 1'b1;
    chk("t5_ready_low", sample_ready, 0);
    step();
    send(16'sd10, 16'sd0);
    chk("t5_restart", pid_out, 20);
    // T6: RESET mid-computation, then back-to-back valid
    accept_only(16'sd100, 16'sd0);
    step();
    step();
    RESET = 1'b1;
    step();
    chk("t6_ready", sample_ready, 0);
    RESET = 1'b0;
    kp = 16'd256; ki = 0; kd = 0;
    setpoint = 16'sd50; sample = 16'sd40; sample_valid = 1'b1;
    n = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (accepted) begin
        if (last >= 0) chk("b2b_gap", cyc - last, 6);
        last = cyc;
        n++;
      end
    end
    sample_valid = 1'b0;
    chk("b2b_count", n, 7);
    repeat (8) step();
    // randomized stream with occasional Start drops
    pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        setpoint = 16'($urandom);
        sample = $urandom_range(0, 1) ? 16'($urandom) : setpoint + 16'($urandom_range(0, 400)) - 16'sd200;
        kp = 16'($urandom_range(0, 600));
        ki = 16'($urandom_range(0, 8));
        kd = 16'($urandom_range(0, 600));
        sample_valid = 1'b1;
        pend = 1'b1;
      end
      Start = $urandom_range(0, 49) != 0;
      step();
      if (accepted) begin pend = 1'b0; sample_valid = 1'b0; end
    end
    sample_valid = 1'b0;
    Start = 1'b1;
    repeat (10) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
